div_seq: RTL
============

Name: div_seq

Overview:
- Sequential unsigned restoring divider: dividend / divisor = quotient, remainder.
- Produces one quotient bit per clock.
- Companion to the shift-add multiplier in the arithmetic datapath. Uses the same start/ack handshake, so control FSMs can drive either unit the same way.
- Intended for multi-cycle DIVU/REMU in the ALU path.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- ack  input  1  consumer acknowledge; sampled only in DONE.
- dividend  input  WIDTH  numerator; sampled on the accepting edge only.
- divisor  input  WIDTH  denominator; sampled on the accepting edge only.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- busy  output  1  high in CALC.
- done  output  1  high in DONE.
- div_by_zero  output  1  high in DONE when the latched divisor was 0.

Behaviour:
- Reset is asynchronous:
  - state=IDLE.
  - quotient, remainder, busy, done and div_by_zero all 0.
  - Internal registers 0.
  - Applies at any time, including mid-CALC; the operation in progress is discarded with no partial result.
- States are one-hot: IDLE, CALC, DONE. No other state is reachable; an illegal encoding returns to IDLE on the next edge.
- IDLE:
  - start=0: stay.
  - start=1, divisor!=0: latch dividend into quo_reg, divisor into dvs_reg; rem_reg (WIDTH+1 bits) <= 0; count <= 0; -> CALC.
  - start=1, divisor==0: quotient <= all ones, remainder <= dividend, div_by_zero <= 1; -> DONE. Latency is 1 edge.
- CALC, one restoring step per cycle:
  - shifted = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]}.
  - trial = shifted - {0, dvs_reg}, computed at WIDTH+1 bits.
  - If trial[WIDTH]==0: rem_reg <= trial, quo_reg <= {quo_reg[WIDTH-2:0], 1}.
  - Otherwise: rem_reg <= shifted, quo_reg <= {quo_reg[WIDTH-2:0], 0}.
  - count <= count + 1. count is $clog2(WIDTH)+1 bits, so it does not wrap.
  - When count == WIDTH-1 (the final step): quotient <= the new quo value, remainder <= new rem[WIDTH-1:0], div_by_zero <= 0; -> DONE.
- Latency: if start is accepted at edge E, done is high after edge E+WIDTH (32 cycles at default). The step count is exactly WIDTH with no early termination, so latency is data-independent.
- DONE:
  - ack=1: -> IDLE on that edge.
  - ack=0: stay.
  - done and div_by_zero fall when leaving DONE.
- quotient and remainder hold their last values after DONE until the next completed operation. They do not change during CALC.
- start outside IDLE is ignored, and is not queued.
- start and ack both high in DONE: go to IDLE only. The start is not accepted that cycle; the requester must hold start one more cycle.
- ack outside DONE is ignored.
- Operand inputs may change freely after the accepting edge.
- busy = (state==CALC). done = (state==DONE). Both are decoded from registered state; no combinational path from inputs to outputs.
- Arithmetic invariant on every non-zero-divisor completion: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Basic division: dividend=100, divisor=7, start pulsed 1 cycle. busy high for 32 cycles; done rises exactly 32 edges after the accept edge; quotient=14, remainder=2, div_by_zero=0. Then ack=1 for 1 cycle -> done=0 and state IDLE next cycle; outputs held at 14/2.
- Extremes:
  - 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
  - 0xFFFFFFFF/0xFFFFFFFF -> q=1, r=0.
  - 5/9 -> q=0, r=5.
  - 0/3 -> q=0, r=0.
- Divide by zero: dividend=0x1234, divisor=0, start -> done after 1 edge, q=0xFFFFFFFF, r=0x1234, div_by_zero=1. A following 10/3 completes with q=3, r=1, div_by_zero=0.
- Handshake:
  - start held high throughout: it is not re-accepted during CALC.
  - start toggled during CALC: the result is unaffected.
  - start=ack=1 in DONE -> IDLE, and the operation starts on the next edge only.
  - ack held in IDLE: no effect.
- Reset mid-operation: assert rst at cycle 10 of CALC for 123456/789 -> all outputs 0 immediately (asynchronous). A new 123456/789 after release yields q=156, r=372 with full 32-cycle latency.
- Random regression: 1000 random pairs (divisor!=0) with back-to-back start after each ack. Check the invariant q*d+r==n, r<d, and fixed latency 32 on each.

Source files
------------

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, fixed WIDTH-cycle latency,
// start/ack handshake shared with the shift-add multiplier.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ack,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    // The partial remainder is always below the divisor, so its extra top bit
    // is never set and only the low WIDTH bits are kept.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        quo_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_CALC: begin
                // Restoring step: keep the subtraction only if it did not borrow.
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    dbz_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                dbz_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;

endmodule
